mm_swdt: RTL and testbench
==========================

# mm_swdt

System watchdog timer that acts as slave S2 on the memory-mapped register bus and answers the interconnect's slave-side address, write-data and write-enable signals. It decodes its two registers, SWDT_CTRL and SWDT_VAL, and returns read data to the interconnect's S2 read-data input. A prescaled down-counter must be kicked by software before it expires. On expiry the block raises a level interrupt toward the interrupt controller (S1) and, if enabled, drives a fixed-length active-low system reset pulse.

## Interface
- MM_ADDR_WIDTH, 8, bus address width
- MM_DATA_WIDTH, 16, bus data width
- REG_ADDR_SWDT_CTRL, 'h0A, control/status register address
- REG_ADDR_SWDT_VAL, 'h0C, reload/count register address
- PRESCALE_DIV, 1000, clk_sys_i cycles per watchdog tick (≥2)
- RELOAD_DEF, 16'hFFFF, reload value after reset
- RST_PULSE_LEN, 16, wdt_rst_n_o low duration in cycles (≥1)

Ports:
- clk_sys_i  in  1  system clock; the block's only clock
- rst_n_i  in  1  reset, synchronous, active-low
- s_addr_i  in  MM_ADDR_WIDTH  register address from the interconnect
- s_wdata_i  in  MM_DATA_WIDTH  write data
- s_we_i  in  1  write enable, level; may be held for several cycles
- s_rdata_o  out  MM_DATA_WIDTH  read data, combinational from s_addr_i and register state
- wdt_int_o  out  1  timeout interrupt, equal to CTRL.TO
- wdt_rst_n_o  out  1  system reset request, active-low pulse

## Operation
- CTRL bits:
  - [0] EN: run enable
  - [1] RST_EN: reset output enable
  - [2] KICK: write 1 to reload; always reads 0
  - [3] TO: sticky timeout flag; write 1 to clear
  - [15:4]: read 0, writes ignored
- VAL register:
  - Write: sets `reload` and loads the counter with the written value.
  - Read: returns the current counter value.
- Write commit: one write per rising edge of s_we_i.
  - The block keeps a registered copy `we_d`.
  - A write commits at the clock edge where s_we_i=1 and we_d=0.
  - A held s_we_i does not repeat the write.
  - Writes to other addresses are ignored.
- Read decode:
  - CTRL address returns {12'b0, TO, 1'b0, RST_EN, EN}.
  - VAL address returns the counter.
  - Any other address returns 0.
  - s_rdata_o is 0 while rst_n_i=0.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1 while EN=1 and produces a 1-cycle tick at the terminal count.
  - Cleared while EN=0 and on every kick or VAL write.
- FSM states:
  - IDLE: EN=0. Counter holds its value. Setting EN moves to RUN.
  - RUN: on a tick, if counter>1 the counter decrements. Otherwise a timeout occurs:
    - TO is set and the counter reloads.
    - If RST_EN=1, go to PULSE; otherwise stay in RUN.
    - Clearing EN moves to IDLE.
  - PULSE: wdt_rst_n_o=0 for RST_PULSE_LEN cycles, then return to RUN (or to IDLE if EN=0). Counting is suspended in this state.
- Reload arithmetic:
  - A reload of N gives a timeout after N ticks.
  - N=0 behaves as N=1.
  - The counter never wraps below 0.
- Simultaneous events:
  - Kick or VAL write on the same cycle as a tick: the write wins; no decrement, no timeout.
  - TO clear on the same cycle as a new timeout: TO stays set.
  - EN cleared during PULSE: the pulse runs to completion.

## Timing
- Reset values:
  - s_rdata_o=0, wdt_int_o=0, wdt_rst_n_o=1
  - CTRL=0, reload=counter=RELOAD_DEF, prescaler=0, we_d=0, state IDLE
- Writes take effect at the committing edge; the new value is visible on s_rdata_o in the same cycle after that edge. The interconnect adds one register stage on top of this.
- Timeout:
  - TO and wdt_int_o rise at the edge following the terminal tick.
  - wdt_rst_n_o falls at that same edge and rises exactly RST_PULSE_LEN cycles later.
- Reset asserted mid-PULSE: wdt_rst_n_o returns to 1 at the next clock edge, and all state returns to its reset value.
- Period from enable to first timeout with reload N: N×PRESCALE_DIV cycles, ±1 cycle.

## Structure
- Shared include file mm_regs.vh holds:
  - register addresses, which are also used by the interconnect
  - CTRL bit positions
  - FSM state encodings
- The prescaler is one sub-module, swdt_prescaler. It takes clk, rst_n, enable and clear as inputs and produces the tick output.

## Test plan
- Reset: reads of CTRL=0x0000 and VAL=0xFFFF; wdt_rst_n_o=1; wdt_int_o=0.
- PRESCALE_DIV=4, write VAL=3, CTRL=0x0003 → after 12±1 cycles TO=1, wdt_int_o=1, wdt_rst_n_o low for exactly 16 cycles; VAL reads 3 afterwards.
- Same setup with a CTRL=0x0005 (kick) write every 8 cycles → no timeout over 200 cycles; CTRL reads KICK as 0.
- s_we_i held high for 5 cycles while writing VAL=0x0010 → exactly one write; the counter loads 0x0010 once.
- RST_EN=0 with timeout → wdt_int_o=1 and wdt_rst_n_o stays 1; writing CTRL=0x0009 clears TO while EN stays 1.
- rst_n_i asserted 5 cycles into a pulse → wdt_rst_n_o=1 at the next edge and all registers return to reset values.

Source files
------------

// File: rtl/mm_swdt_pkg.sv
// mm_swdt_pkg: shared constants for the system watchdog (slave S2).
// Holds the register addresses (also used by the interconnect decoder),
// the SWDT_CTRL bit positions and the watchdog FSM state type.
package mm_swdt_pkg;

    localparam logic [7:0] SWDT_CTRL_ADDR = 8'h0A;
    localparam logic [7:0] SWDT_VAL_ADDR  = 8'h0C;

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_RST_EN_BIT = 1;
    localparam int unsigned CTRL_KICK_BIT   = 2;
    localparam int unsigned CTRL_TO_BIT     = 3;

    typedef enum logic [1:0] {
        SWDT_IDLE  = 2'd0,
        SWDT_RUN   = 2'd1,
        SWDT_PULSE = 2'd2
    } swdt_state_e;

endpackage

// File: rtl/mm_swdt_prescaler.sv
// swdt_prescaler: divides clk_i into a one-cycle watchdog tick.
// Ports:
//   clk_i     system clock
//   rst_n_i   synchronous active-low reset
//   enable_i  count enable; the count holds while low
//   clear_i   forces the count to 0, dominates enable_i
//   tick_o    high for one cycle when the count sits at PRESCALE_DIV-1
module swdt_prescaler #(
    parameter int unsigned PRESCALE_DIV = 1000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CNT_W = $clog2(PRESCALE_DIV);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
        end
    end

    // A clear in the terminal cycle swallows the tick.
    always_comb begin
        tick_o = enable_i & ~clear_i & (cnt_q == TERM);
    end

endmodule

// File: rtl/mm_swdt.sv
// mm_swdt: memory-mapped system watchdog timer, bus slave S2.
// Ports:
//   clk_sys_i    system clock
//   rst_n_i      synchronous active-low reset
//   s_addr_i     register address from the interconnect
//   s_wdata_i    write data
//   s_we_i       level write enable; a write commits on its rising edge
//   s_rdata_o    combinational read data (0 while in reset)
//   wdt_int_o    timeout interrupt, mirrors CTRL.TO
//   wdt_rst_n_o  active-low system reset pulse, RST_PULSE_LEN cycles
module mm_swdt
    import mm_swdt_pkg::*;
#(
    parameter int unsigned MM_ADDR_WIDTH = 8,
    parameter int unsigned MM_DATA_WIDTH = 16,
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_SWDT_CTRL = MM_ADDR_WIDTH'(SWDT_CTRL_ADDR),
    parameter logic [MM_ADDR_WIDTH-1:0] REG_ADDR_SWDT_VAL  = MM_ADDR_WIDTH'(SWDT_VAL_ADDR),
    parameter int unsigned PRESCALE_DIV  = 1000,
    parameter logic [MM_DATA_WIDTH-1:0] RELOAD_DEF = MM_DATA_WIDTH'(16'hFFFF),
    parameter int unsigned RST_PULSE_LEN = 16
) (
    input  logic                     clk_sys_i,
    input  logic                     rst_n_i,
    input  logic [MM_ADDR_WIDTH-1:0] s_addr_i,
    input  logic [MM_DATA_WIDTH-1:0] s_wdata_i,
    input  logic                     s_we_i,
    output logic [MM_DATA_WIDTH-1:0] s_rdata_o,
    output logic                     wdt_int_o,
    output logic                     wdt_rst_n_o
);

    localparam int unsigned PW = $clog2(RST_PULSE_LEN + 1);

    logic                     we_q;
    logic                     en_q;
    logic                     rst_en_q;
    logic                     to_q;
    logic [MM_DATA_WIDTH-1:0] reload_q;
    logic [MM_DATA_WIDTH-1:0] cnt_q;
    logic [PW-1:0]            pcnt_q;
    logic                     rst_n_q;
    swdt_state_e              state_q;

    logic commit, wr_ctrl, wr_val, kick;
    logic pre_en, pre_clr, tick, timeout;

    always_comb begin
        commit  = s_we_i & ~we_q;
        wr_ctrl = commit & (s_addr_i == REG_ADDR_SWDT_CTRL);
        wr_val  = commit & (s_addr_i == REG_ADDR_SWDT_VAL);
        kick    = wr_ctrl & s_wdata_i[CTRL_KICK_BIT];
        // Kicks and VAL writes restart the tick period as well as the count.
        pre_clr = ~en_q | kick | wr_val;
        pre_en  = en_q & (state_q != SWDT_PULSE);
        // tick is already masked by pre_clr, so a write always beats a timeout.
        timeout = tick & (state_q == SWDT_RUN) & (cnt_q <= MM_DATA_WIDTH'(1));
    end

    swdt_prescaler #(
        .PRESCALE_DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk_i   (clk_sys_i),
        .rst_n_i (rst_n_i),
        .enable_i(pre_en),
        .clear_i (pre_clr),
        .tick_o  (tick)
    );

    always_ff @(posedge clk_sys_i) begin
        if (!rst_n_i) begin
            we_q     <= 1'b0;
            en_q     <= 1'b0;
            rst_en_q <= 1'b0;
            to_q     <= 1'b0;
            reload_q <= RELOAD_DEF;
            cnt_q    <= RELOAD_DEF;
            pcnt_q   <= '0;
            rst_n_q  <= 1'b1;
            state_q  <= SWDT_IDLE;
        end else begin
            we_q <= s_we_i;

            if (wr_ctrl) begin
                en_q     <= s_wdata_i[CTRL_EN_BIT];
                rst_en_q <= s_wdata_i[CTRL_RST_EN_BIT];
            end

            // A new timeout outranks a simultaneous write-1-to-clear.
            if (timeout) begin
                to_q <= 1'b1;
            end else if (wr_ctrl && s_wdata_i[CTRL_TO_BIT]) begin
                to_q <= 1'b0;
            end

            if (wr_val) begin
                reload_q <= s_wdata_i;
                cnt_q    <= s_wdata_i;
            end else if (kick) begin
                cnt_q <= reload_q;
            end else if (tick && state_q == SWDT_RUN) begin
                cnt_q <= (cnt_q > MM_DATA_WIDTH'(1)) ? cnt_q - 1'b1 : reload_q;
            end

            case (state_q)
                SWDT_IDLE: begin
                    if (en_q) begin
                        state_q <= SWDT_RUN;
                    end
                end
                SWDT_RUN: begin
                    if (timeout && rst_en_q) begin
                        state_q <= SWDT_PULSE;
                        rst_n_q <= 1'b0;
                        pcnt_q  <= '0;
                    end else if (!en_q) begin
                        state_q <= SWDT_IDLE;
                    end
                end
                SWDT_PULSE: begin
                    if (pcnt_q == PW'(RST_PULSE_LEN - 1)) begin
                        rst_n_q <= 1'b1;
                        state_q <= en_q ? SWDT_RUN : SWDT_IDLE;
                    end else begin
                        pcnt_q <= pcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= SWDT_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_rdata_o = '0;
        if (rst_n_i) begin
            if (s_addr_i == REG_ADDR_SWDT_CTRL) begin
                s_rdata_o[CTRL_EN_BIT]     = en_q;
                s_rdata_o[CTRL_RST_EN_BIT] = rst_en_q;
                s_rdata_o[CTRL_TO_BIT]     = to_q;
            end else if (s_addr_i == REG_ADDR_SWDT_VAL) begin
                s_rdata_o = cnt_q;
            end
        end
    end

    assign wdt_int_o   = to_q;
    assign wdt_rst_n_o = rst_n_q;

endmodule

// File: tb/tb_mm_swdt.sv
// tb_mm_swdt: self-checking bench for mm_swdt with a per-edge reference
// model built from the register-level behaviour (integer counters, no FSM).
module tb_mm_swdt;

    localparam int unsigned DIV = 4;
    localparam int unsigned LEN = 16;
    localparam logic [7:0] A_CTRL = 8'h0A;
    localparam logic [7:0] A_VAL  = 8'h0C;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        wint;
    logic        wrstn;

    always #5 clk = ~clk;

    mm_swdt #(
        .PRESCALE_DIV (DIV),
        .RST_PULSE_LEN(LEN)
    ) dut (
        .clk_sys_i  (clk),
        .rst_n_i    (rst_n),
        .s_addr_i   (addr),
        .s_wdata_i  (wdata),
        .s_we_i     (we),
        .s_rdata_o  (rdata),
        .wdt_int_o  (wint),
        .wdt_rst_n_o(wrstn)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_en = 0, m_rst_en = 0, m_to = 0, m_we_prev = 0;
    int unsigned m_cnt = 32'hFFFF, m_reload = 32'hFFFF;
    int unsigned m_phase = 0, m_pulse_left = 0;

    function automatic logic [15:0] exp_read(input logic [7:0] a);
        if (!rst_n) return 16'h0;
        if (a == A_CTRL) return {12'h0, m_to, 1'b0, m_rst_en, m_en};
        if (a == A_VAL) return 16'(m_cnt);
        return 16'h0;
    endfunction

    always @(posedge clk) begin
        bit commit, wc, wv, kick, clr, active, tick, tmo;
        if (!rst_n) begin
            m_en = 0; m_rst_en = 0; m_to = 0; m_we_prev = 0;
            m_cnt = 32'hFFFF; m_reload = 32'hFFFF;
            m_phase = 0; m_pulse_left = 0;
        end else begin
            commit = we && !m_we_prev;
            wc     = commit && (addr == A_CTRL);
            wv     = commit && (addr == A_VAL);
            kick   = wc && wdata[2];
            clr    = !m_en || kick || wv;
            active = m_en && (m_pulse_left == 0);
            tick   = active && !clr && (m_phase == DIV - 1);
            if (clr) m_phase = 0;
            else if (active) m_phase = (m_phase + 1) % DIV;
            tmo = 0;
            if (wv) begin
                m_reload = 32'(wdata);
                m_cnt    = 32'(wdata);
            end else if (kick) begin
                m_cnt = m_reload;
            end else if (tick) begin
                if (m_cnt > 1) m_cnt = m_cnt - 1;
                else begin
                    tmo   = 1;
                    m_cnt = m_reload;
                end
            end
            if (m_pulse_left > 0) m_pulse_left = m_pulse_left - 1;
            else if (tmo && m_rst_en) m_pulse_left = LEN;
            if (wc && wdata[3]) m_to = 0;
            if (tmo) m_to = 1;
            if (wc) begin
                m_en     = wdata[0];
                m_rst_en = wdata[1];
            end
            m_we_prev = we;
        end
        #1;
        chk("rdata", 32'(rdata), 32'(exp_read(addr)));
        chk("int", 32'(wint), 32'(m_to));
        chk("rstn", 32'(wrstn), 32'(m_pulse_left == 0));
    end

    task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit saw_low;
        rst_n = 1'b0;
        we    = 1'b0;
        addr  = A_CTRL;
        wdata = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_rdata_zero", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ctrl", 32'(rdata), 32'h0000);
        addr = A_VAL;
        #1;
        chk("rst_val", 32'(rdata), 32'hFFFF);
        chk("rst_int", 32'(wint), 32'h0);
        chk("rst_rstn", 32'(wrstn), 32'h1);

        // Timeout with reset pulse: reload 3, DIV 4
        bus_write(A_VAL, 16'h0003);
        addr  = A_CTRL;
        wdata = 16'h0003;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        n  = 0;
        while (!wint && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("period_12pm1", 32'(n >= 11 && n <= 13), 32'h1);
        chk("to_int", 32'(wint), 32'h1);
        chk("to_bit", 32'(rdata[3]), 32'h1);
        n = 0;
        while (!wrstn && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_len", 32'(n), 32'(LEN));
        addr = A_VAL;
        #1;
        chk("val_after_to", 32'(rdata), 32'h0003);

        // Periodic kicks keep the watchdog quiet
        bus_write(A_CTRL, 16'h000F);
        for (int k = 0; k < 25; k++) begin
            repeat (6) @(negedge clk);
            bus_write(A_CTRL, 16'h0005);
        end
        chk("kick_no_int", 32'(wint), 32'h0);
        chk("kick_rstn", 32'(wrstn), 32'h1);
        addr = A_CTRL;
        #1;
        chk("kick_reads_0", 32'(rdata), 32'h0001);

        // Held write enable commits once
        bus_write(A_CTRL, 16'h0000);
        addr  = A_VAL;
        wdata = 16'h0010;
        we    = 1'b1;
        @(negedge clk);
        wdata = 16'h0020;
        repeat (4) @(negedge clk);
        we = 1'b0;
        @(negedge clk);
        chk("held_we_once", 32'(rdata), 32'h0010);

        // Timeout without reset enable, then clear TO
        bus_write(A_VAL, 16'h0002);
        bus_write(A_CTRL, 16'h0001);
        n = 0;
        saw_low = 0;
        while (!wint && n < 40) begin
            @(negedge clk);
            n++;
            if (!wrstn) saw_low = 1;
        end
        chk("nores_int", 32'(wint), 32'h1);
        bus_write(A_CTRL, 16'h0009);
        addr = A_CTRL;
        #1;
        chk("to_cleared", 32'(rdata), 32'h0001);
        chk("to_cleared_int", 32'(wint), 32'h0);
        repeat (20) begin
            @(negedge clk);
            if (!wrstn) saw_low = 1;
        end
        chk("nores_rstn_high", 32'(saw_low), 32'h0);

        // Reset asserted mid-pulse
        bus_write(A_VAL, 16'h0002);
        bus_write(A_CTRL, 16'h000B);
        n = 0;
        while (wrstn && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_start", 32'(wrstn), 32'h0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rstn", 32'(wrstn), 32'h1);
        chk("midrst_int", 32'(wint), 32'h0);
        chk("midrst_rdata", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        addr  = A_CTRL;
        @(negedge clk);
        chk("midrst_ctrl", 32'(rdata), 32'h0000);
        addr = A_VAL;
        #1;
        chk("midrst_val", 32'(rdata), 32'hFFFF);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            rst_n = ($urandom_range(0, 999) != 0);
            r = $urandom_range(0, 9);
            if (r < 5) begin
                addr  = A_CTRL;
                wdata = 16'($urandom);
                wdata[0] = ($urandom_range(0, 3) != 0);
            end else if (r < 9) begin
                addr  = A_VAL;
                wdata = 16'($urandom_range(0, 5));
            end else begin
                addr  = 8'($urandom);
                wdata = 16'($urandom);
            end
            we = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        we = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
